// File: rtl/sar_divider_qr.sv
// Restoring successive-approximation divider: fixed-point quotient (FRAC_BITS fraction bits) and remainder.
// Define SAR_DIVIDER_SIGNED_EN for two's-complement operands; the default build is unsigned.
module sar_divider_qr #(
    parameter int WIDTH     = 40,
    parameter int FRAC_BITS = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           dividend,
    input  logic [WIDTH-1:0]           divisor,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH+FRAC_BITS-1:0] quotient,
    output logic [WIDTH-1:0]           remainder,
    output logic                       div_by_zero,
    output logic                       overflow
);
    localparam int QW = WIDTH + FRAC_BITS;
    localparam int CW = (QW > 1) ? $clog2(QW) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

    state_t           state_r;
    state_t           state_s;
    // Dividend bits leave at the top while quotient bits enter at the bottom.
    logic [QW-1:0]    dq_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] rem_r;
    logic [CW-1:0]    cnt_r;
    logic             zero_r;
    logic             zero_in_s;
    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dvs_mag_s;
    logic [WIDTH:0]   pr_s;
    logic             ge_s;
    logic [WIDTH-1:0] rem_nxt_s;
    logic [QW-1:0]    dq_nxt_s;
    logic [QW-1:0]    res_q_s;
    logic [WIDTH-1:0] res_r_s;
    logic             res_dz_s;

`ifdef SAR_DIVIDER_SIGNED_EN
    logic             neg_q_r;
    logic             neg_d_r;
    logic             ovf_r;
    logic             ovf_in_s;
    logic             res_ovf_s;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [QW-1:0] neg_qw(input logic [QW-1:0] v);
        return ~v + {{(QW-1){1'b0}}, 1'b1};
    endfunction

    // Operand magnitudes and the single overflowing operand pair
    always_comb begin
        dvd_mag_s = dividend[WIDTH-1] ? neg_w(dividend) : dividend;
        dvs_mag_s = divisor[WIDTH-1] ? neg_w(divisor) : divisor;
        ovf_in_s  = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == {WIDTH{1'b1}});
    end
`else
    // Unsigned operands are already magnitudes
    always_comb begin
        dvd_mag_s = dividend;
        dvs_mag_s = divisor;
    end
`endif

    // One restoring step plus handshake decodes
    always_comb begin
        zero_in_s = (divisor == {WIDTH{1'b0}});
        accept_s  = (state_r == S_IDLE) && in_valid;
        last_s    = (state_r == S_CALC) && (cnt_r == {CW{1'b0}});
        pr_s      = {rem_r, dq_r[QW-1]};
        ge_s      = (pr_s >= {1'b0, dvs_r});
        rem_nxt_s = ge_s ? (pr_s[WIDTH-1:0] - dvs_r) : pr_s[WIDTH-1:0];
        dq_nxt_s  = {dq_r[QW-2:0], ge_s};
    end

    // State register and datapath; a zero divisor spends one CALC cycle so the result lands after T0+1
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            dq_r    <= {QW{1'b0}};
            dvs_r   <= {WIDTH{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            zero_r  <= 1'b0;
`ifdef SAR_DIVIDER_SIGNED_EN
            neg_q_r <= 1'b0;
            neg_d_r <= 1'b0;
            ovf_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        dq_r    <= QW'(dvd_mag_s) << FRAC_BITS;
                        dvs_r   <= dvs_mag_s;
                        rem_r   <= zero_in_s ? dividend : {WIDTH{1'b0}};
                        cnt_r   <= zero_in_s ? {CW{1'b0}} : CW'(QW - 1);
                        zero_r  <= zero_in_s;
`ifdef SAR_DIVIDER_SIGNED_EN
                        neg_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_d_r <= dividend[WIDTH-1];
                        ovf_r   <= ovf_in_s;
`endif
                    end
                end
                S_CALC: begin
                    dq_r  <= dq_nxt_s;
                    rem_r <= rem_nxt_s;
                    cnt_r <= cnt_r - 1'b1;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) state_s = S_CALC;
                else          state_s = S_IDLE;
            end
            S_CALC: begin
                if (cnt_r == {CW{1'b0}}) state_s = S_DONE;
                else                     state_s = S_CALC;
            end
            S_DONE: begin
                if (out_ready) state_s = S_IDLE;
                else           state_s = S_DONE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Final result formation, sampled on the last CALC cycle
    always_comb begin
        res_q_s  = dq_nxt_s;
        res_r_s  = rem_nxt_s;
        res_dz_s = 1'b0;
`ifdef SAR_DIVIDER_SIGNED_EN
        res_ovf_s = 1'b0;
        if (zero_r) begin
            res_q_s  = neg_d_r ? {1'b1, {(QW-1){1'b0}}} : {1'b0, {(QW-1){1'b1}}};
            res_r_s  = rem_r;
            res_dz_s = 1'b1;
        end else if (ovf_r) begin
            res_q_s   = {1'b0, {(QW-1){1'b1}}};
            res_r_s   = {WIDTH{1'b0}};
            res_ovf_s = 1'b1;
        end else begin
            res_q_s = neg_q_r ? neg_qw(dq_nxt_s) : dq_nxt_s;
            res_r_s = neg_d_r ? neg_w(rem_nxt_s) : rem_nxt_s;
        end
`else
        if (zero_r) begin
            res_q_s  = {QW{1'b1}};
            res_r_s  = rem_r;
            res_dz_s = 1'b1;
        end else begin
            res_q_s = dq_nxt_s;
            res_r_s = rem_nxt_s;
        end
`endif
    end

    // Registered outputs: held through DONE, flags cleared on the next accept
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= {QW{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
`ifdef SAR_DIVIDER_SIGNED_EN
            overflow    <= 1'b0;
`endif
        end else begin
            in_ready  <= (state_s == S_IDLE);
            out_valid <= (state_s == S_DONE);
            if (last_s) begin
                quotient    <= res_q_s;
                remainder   <= res_r_s;
                div_by_zero <= res_dz_s;
`ifdef SAR_DIVIDER_SIGNED_EN
                overflow    <= res_ovf_s;
`endif
            end else if (accept_s) begin
                div_by_zero <= 1'b0;
`ifdef SAR_DIVIDER_SIGNED_EN
                overflow    <= 1'b0;
`endif
            end
        end
    end

`ifndef SAR_DIVIDER_SIGNED_EN
    assign overflow = 1'b0;
`endif

endmodule

// File: doc/sar_divider_qr.md
# sar_divider_qr

Parametrised successive-approximation divider: takes a WIDTH-bit dividend and divisor, produces a fixed-point quotient with FRAC_BITS fractional bits plus an integer remainder, one quotient bit per clock. It is the next-generation divider for the DSP datapath. It adds:
- valid/ready handshakes on input and output;
- a fractional quotient;
- divide-by-zero and overflow reporting;
- an optional signed mode.

## Interface
- WIDTH, 40: operand width in bits (≥2).
- FRAC_BITS, 0: fractional quotient bits (≥0); QW = WIDTH+FRAC_BITS, N = QW iterations.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block idle, can accept.
- dividend  in  WIDTH  dividend.
- divisor  in  WIDTH  divisor.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  QW  (dividend·2^FRAC_BITS)/divisor, truncated.
- remainder  out  WIDTH  (dividend·2^FRAC_BITS) − quotient·divisor.
- div_by_zero  out  1  divisor was 0.
- overflow  out  1  signed overflow (signed mode only, else 0).

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE. Reset values: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
- IDLE behaviour:
  - in_ready=1.
  - On in_valid&&in_ready, operand magnitudes are registered.
  - The dividend is extended with FRAC_BITS zero LSBs.
  - If divisor≠0, go to CALC with bit counter = N−1.
  - If divisor=0, go to DONE.
- Divide-by-zero result: quotient = all ones, remainder = dividend, div_by_zero=1.
- CALC, per cycle (restoring SAR step):
  - Partial remainder = {rem[WIDTH-1:0], next dividend bit}, held WIDTH+1 bits wide.
  - If the partial remainder ≥ |divisor|: subtract |divisor| and set the quotient bit to 1.
  - Otherwise: keep the partial remainder and set the quotient bit to 0.
  - Quotient bits are produced MSB first.
  - After the bit-0 step, go to DONE.
- DONE behaviour:
  - out_valid=1.
  - Outputs are stable until out_valid&&out_ready, then go to IDLE.
  - out_ready is ignored in other states.
- in_ready=1 only in IDLE; the block never accepts and delivers in the same cycle.
- Operands are sampled only at the accept edge; later changes on dividend/divisor have no effect.
- Flags clear on the next accept.

## Timing
- Accept edge T0.
- divisor≠0: CALC occupies edges T0+1..T0+N; out_valid=1 from after edge T0+N (latency N cycles).
- divisor=0: out_valid=1 from after edge T0+1.
- Minimum initiation interval is N+2 cycles, with out_ready held high.
- out_ready low in DONE holds all outputs indefinitely.
- reset at any edge (mid-CALC or DONE):
  - returns to IDLE with reset values next cycle;
  - discards the partial result;
  - produces no out_valid pulse.
- in_valid asserted during CALC/DONE is not accepted; the source must hold it until in_ready.

## Configuration
- SAR_DIVIDER_SIGNED_EN defined:
  - dividend, divisor, quotient and remainder are two's complement.
  - The magnitude is divided.
  - The quotient is negated when the operand signs differ (truncation toward zero).
  - The remainder takes the dividend's sign.
  - Most-negative dividend / −1 sets overflow=1 and saturates the quotient to the maximum positive QW value, with remainder=0.
  - Divide by zero sets quotient to the maximum positive (dividend ≥0) or minimum negative (dividend <0) value.
- SAR_DIVIDER_SIGNED_EN undefined:
  - all values are unsigned;
  - overflow is tied 0;
  - no sign logic is synthesised.

## Test plan
- WIDTH=40, FRAC_BITS=0, unsigned: 425_332_234 / 62_254 → quotient 6_832, remainder 12_906, out_valid 40 cycles after accept.
- WIDTH=16, FRAC_BITS=8: 7 / 2 → quotient 0x380 (3.5), remainder 0, latency 24. Then 1 / 3 → quotient 0x55, remainder 1.
- Divide by zero, unsigned WIDTH=16: 100 / 0 → div_by_zero=1, quotient 0xFFFF, remainder 100, out_valid after edge T0+1.
- Backpressure: out_ready low for 10 cycles in DONE → outputs and out_valid stable, in_ready=0, a new in_valid is ignored. Raise out_ready → IDLE next cycle, then the pending operand is accepted.
- Reset mid-operation: assert reset at cycle 10 of a 40-cycle CALC → next cycle in_ready=1, out_valid=0, all outputs 0. A subsequent 1000 / 7 → quotient 142, remainder 6.
- SAR_DIVIDER_SIGNED_EN, WIDTH=16, FRAC_BITS=0:
  - −7 / 2 → quotient −3, remainder −1.
  - 7 / −2 → quotient −3, remainder 1.
  - −32768 / −1 → overflow=1, quotient 32767, remainder 0.
